// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and width default for the execute-stage ALU
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1100;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational ALU datapath: operands and opcode to result and signed overflow
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [4:0]       shamt;
   logic             a_sign;
   logic             b_sign;

   // Adder and subtractor are shared between arithmetic ops and overflow detection
   assign sum    = a + b;
   assign diff   = a - b;
   assign shamt  = b[4:0];
   assign a_sign = a[WIDTH-1];
   assign b_sign = b[WIDTH-1];

   // Operation select; unassigned opcodes fall to zero so nothing is held over
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alu_control)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD: begin
            result   = sum;
            overflow = (a_sign == b_sign) && (sum[WIDTH-1] != a_sign);
         end
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SUB: begin
            result   = diff;
            overflow = (a_sign != b_sign) && (diff[WIDTH-1] != a_sign);
         end
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_NOR:  result = ~(a | b);
         default: begin
            result   = '0;
            overflow = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 32-bit ALU with Zero and signed Overflow flags
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUControl,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow
);

   logic [WIDTH-1:0] next_result;
   logic             next_overflow;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .a           (A),
      .b           (B),
      .alu_control (ALUControl),
      .result      (next_result),
      .overflow    (next_overflow)
   );

   // Output register; Zero derives from the value being loaded so it always matches Result
   always_ff @(posedge clk) begin
      if (rst) begin
         Result   <= '0;
         Zero     <= 1'b1;
         Overflow <= 1'b0;
      end else begin
         Result   <= next_result;
         Zero     <= (next_result == '0);
         Overflow <= next_overflow;
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: directed edges plus random ops against a reference model
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALUControl;
   logic [31:0] Result;
   logic        Zero;
   logic        Overflow;

   int total = 0;
   int bad   = 0;

   alu dut (
      .clk        (clk),
      .rst        (rst),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .Result     (Result),
      .Zero       (Zero),
      .Overflow   (Overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Reference model written from the arithmetic definitions with wide signed integers
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                 output logic [31:0] r, output logic ov);
      longint sa, sb, wide;
      int     sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      ov = 1'b0;
      r  = 32'd0;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2: begin
            wide = sa + sb;
            r = wide[31:0];
            ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd3:  r = a ^ b;
         4'd4:  r = 32'((64'(a) * (64'd1 << sh)));
         4'd5:  r = 32'(64'(a) / (64'd1 << sh));
         4'd6: begin
            wide = sa - sb;
            r = wide[31:0];
            ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd8: begin
            // floor division by 2^sh implements sign-filling shift
            wide = sa >= 0 ? sa / (64'sd1 <<< sh) : -((-sa + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh));
            r = wide[31:0];
         end
         4'd9:  r = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
         4'd12: r = ~(a | b);
         default: r = 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      A = a; B = b; ALUControl = op;
      @(posedge clk); #1;
   endtask

   task automatic expect3(input string tag, input logic [31:0] r, input logic z, input logic ov);
      check({tag, ".res"}, Result, r);
      check({tag, ".zero"}, 32'(Zero), 32'(z));
      check({tag, ".ovf"}, 32'(Overflow), 32'(ov));
   endtask

   initial begin
      logic [31:0] er;
      logic        eo;
      logic [31:0] ra, rb;
      logic [3:0]  rop;

      rst = 1'b1; A = 32'd5; B = 32'd7; ALUControl = 4'b0010;
      @(posedge clk); #1;
      expect3("reset", 32'd0, 1'b1, 1'b0);
      rst = 1'b0;

      drive(32'h10, 32'h20, 4'b0010);             expect3("add", 32'h30, 1'b0, 1'b0);
      drive(32'h30, 32'h10, 4'b0110);             check("sub.res", Result, 32'h20); check("sub.zero", 32'(Zero), 0);
      drive(32'h12345678, 32'h12345678, 4'b0110); expect3("sub_eq", 32'h0, 1'b1, 1'b0);
      drive(32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0000); expect3("and", 32'h0, 1'b1, 1'b0);
      drive(32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0001); expect3("or", 32'hFFFFFFFF, 1'b0, 1'b0);
      drive(32'hF0F0F0F0, 32'h0F0F0F0F, 4'b1100); expect3("nor", 32'h0, 1'b1, 1'b0);
      drive(32'h5, 32'h5, 4'b0010);               check("pre_undef", Result, 32'hA);
      drive(32'h1, 32'h1, 4'b1111);               expect3("undef", 32'h0, 1'b1, 1'b0);
      drive(32'h7FFFFFFF, 32'h1, 4'b0010);        expect3("add_ovf", 32'h80000000, 1'b0, 1'b1);
      drive(32'hFFFFFFFF, 32'h1, 4'b0010);        expect3("add_wrap", 32'h0, 1'b1, 1'b0);
      drive(32'h80000000, 32'h1, 4'b0110);        expect3("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1);
      drive(32'hFFFFFFFF, 32'h1, 4'b0111);        check("slt", Result, 32'h1);
      drive(32'hFFFFFFFF, 32'h1, 4'b1001);        check("sltu", Result, 32'h0);
      drive(32'h80000000, 32'h4, 4'b1000);        check("sra", Result, 32'hF8000000);
      drive(32'h80000000, 32'h24, 4'b0101);       check("srl_hi_ignored", Result, 32'h08000000);
      drive(32'h89ABCDEF, 32'hFFFFFFE0, 4'b0100); check("sll_by0", Result, 32'h89ABCDEF);

      drive(32'h1, 32'h1, 4'b0010);               check("pre_rst", Result, 32'h2);
      rst = 1'b1;
      drive(32'h1, 32'h1, 4'b0010);               expect3("mid_rst", 32'h0, 1'b1, 1'b0);
      rst = 1'b0;
      drive(32'h1, 32'h1, 4'b0010);               expect3("post_rst", 32'h2, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = 4'($urandom_range(0, 15));
         if (i % 4 == 0) rb = ra;
         if (i % 7 == 0) ra = 32'h7FFFFFFF ^ 32'($urandom_range(0, 3));
         model(ra, rb, rop, er, eo);
         drive(ra, rb, rop);
         expect3($sformatf("rand%0d_op%0h", i, rop), er, (er == 32'd0), eo);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
